// File: rtl/wb_master_protocol_checker.sv
// Passive Wishbone B4 pipelined master-port monitor: tracks requests and responses per
// bus cycle and latches sticky protocol-violation flags. Drives nothing onto the bus.
module wb_master_protocol_checker #(
    parameter int AW                   = 32,
    parameter int DW                   = 32,
    parameter int F_LGDEPTH            = 4,
    parameter int F_MAX_STALL          = 0,
    parameter int F_MAX_ACK_DELAY      = 0,
    parameter int F_OPT_RMW_BUS_OPTION = 1,
    parameter int F_OPT_DISCONTINUOUS  = 0
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_wb_cyc,
    input  logic                 i_wb_stb,
    input  logic                 i_wb_we,
    input  logic [AW-1:0]        i_wb_addr,
    input  logic [DW-1:0]        i_wb_data,
    input  logic [DW/8-1:0]      i_wb_sel,
    input  logic                 i_wb_ack,
    input  logic                 i_wb_stall,
    input  logic [DW-1:0]        i_wb_idata,
    input  logic                 i_wb_err,
    output logic [F_LGDEPTH-1:0] o_f_nreqs,
    output logic [F_LGDEPTH-1:0] o_f_nacks,
    output logic [F_LGDEPTH-1:0] o_f_outstanding,
    output logic [9:0]           o_viol,
    output logic                 o_viol_any
);

    localparam int SW = DW / 8;
    localparam int TW = 16;
    localparam logic [F_LGDEPTH-1:0] CNT_MAX   = '1;
    localparam logic [TW-1:0]        TMR_MAX   = '1;
    localparam logic [TW-1:0]        STALL_LIM = TW'(F_MAX_STALL);
    localparam logic [TW-1:0]        ACK_LIM   = TW'(F_MAX_ACK_DELAY);
    localparam bit CHK_STALL = (F_MAX_STALL > 0);
    localparam bit CHK_ACK   = (F_MAX_ACK_DELAY > 0);
    localparam bit CHK_DISC  = (F_OPT_DISCONTINUOUS == 0);
    localparam bit CHK_IDLE  = (F_OPT_RMW_BUS_OPTION == 0);

    logic [F_LGDEPTH-1:0] nreqs_q, nreqs_d, nacks_q, nacks_d, outstanding;
    logic [TW-1:0]        stall_tmr_q, stall_tmr_d, ack_tmr_q, ack_tmr_d;
    logic [TW-1:0]        stall_run, ack_run;
    logic                 stb_seen_q, stb_seen_d;
    logic [9:0]           viol_q, viol_d, viol_set;
    logic                 p_cyc_q, p_stb_q, p_stall_q, p_we_q;
    logic [AW-1:0]        p_addr_q;
    logic [DW-1:0]        p_data_q;
    logic [SW-1:0]        p_sel_q;
    logic                 accept, any_resp, terminate, req_changed;
    logic                 unused_idata;

    assign unused_idata = ^i_wb_idata;

    always_comb begin
        accept      = i_wb_cyc & i_wb_stb & !i_wb_stall;
        any_resp    = i_wb_ack | i_wb_err;
        terminate   = !i_wb_cyc | i_wb_err;
        outstanding = nreqs_q - nacks_q;

        nreqs_d = nreqs_q;
        nacks_d = nacks_q;
        if (terminate) begin
            nreqs_d = '0;
            nacks_d = '0;
        end else begin
            if (accept && nreqs_q != CNT_MAX) nreqs_d = nreqs_q + 1'b1;
            if (i_wb_ack && nacks_q != CNT_MAX) nacks_d = nacks_q + 1'b1;
        end

        // Run lengths include the current clock so a limit of N trips after N clocks.
        stall_run = '0;
        if (i_wb_cyc && i_wb_stb && i_wb_stall)
            stall_run = (stall_tmr_q == TMR_MAX) ? stall_tmr_q : stall_tmr_q + 1'b1;
        ack_run = '0;
        if (i_wb_cyc && outstanding != '0 && !any_resp)
            ack_run = (ack_tmr_q == TMR_MAX) ? ack_tmr_q : ack_tmr_q + 1'b1;
        stall_tmr_d = terminate ? '0 : stall_run;
        ack_tmr_d   = terminate ? '0 : ack_run;

        stb_seen_d = i_wb_cyc & (stb_seen_q | i_wb_stb);

        req_changed = p_cyc_q & p_stb_q & p_stall_q & i_wb_cyc & i_wb_stb &
                      ((i_wb_addr != p_addr_q) | (i_wb_we != p_we_q) |
                       (i_wb_sel != p_sel_q) | (i_wb_we & (i_wb_data != p_data_q)));

        viol_set    = '0;
        viol_set[0] = i_wb_stb & !i_wb_cyc;
        viol_set[1] = req_changed;
        viol_set[2] = i_wb_cyc & i_wb_stb & (outstanding != '0) & (i_wb_we != p_we_q);
        viol_set[3] = CHK_DISC & i_wb_cyc & i_wb_stb & !p_stb_q & stb_seen_q;
        viol_set[4] = CHK_IDLE & i_wb_cyc & !i_wb_stb & (outstanding == '0) & p_cyc_q;
        viol_set[5] = any_resp & (outstanding == '0);
        viol_set[6] = any_resp & !i_wb_cyc;
        viol_set[7] = CHK_STALL & (stall_run >= STALL_LIM);
        viol_set[8] = CHK_ACK & (ack_run >= ACK_LIM);
        viol_set[9] = accept & !i_wb_err & (nreqs_q == CNT_MAX);
        viol_d      = viol_q | viol_set;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            nreqs_q     <= '0;
            nacks_q     <= '0;
            stall_tmr_q <= '0;
            ack_tmr_q   <= '0;
            stb_seen_q  <= 1'b0;
            viol_q      <= '0;
            p_cyc_q     <= 1'b0;
            p_stb_q     <= 1'b0;
            p_stall_q   <= 1'b0;
            p_we_q      <= 1'b0;
            p_addr_q    <= '0;
            p_data_q    <= '0;
            p_sel_q     <= '0;
        end else begin
            nreqs_q     <= nreqs_d;
            nacks_q     <= nacks_d;
            stall_tmr_q <= stall_tmr_d;
            ack_tmr_q   <= ack_tmr_d;
            stb_seen_q  <= stb_seen_d;
            viol_q      <= viol_d;
            p_cyc_q     <= i_wb_cyc;
            p_stb_q     <= i_wb_stb;
            p_stall_q   <= i_wb_stall;
            p_we_q      <= i_wb_we;
            p_addr_q    <= i_wb_addr;
            p_data_q    <= i_wb_data;
            p_sel_q     <= i_wb_sel;
        end
    end

    assign o_f_nreqs       = nreqs_q;
    assign o_f_nacks       = nacks_q;
    assign o_f_outstanding = outstanding;
    assign o_viol          = viol_q;
    assign o_viol_any      = |viol_q;

endmodule

// File: tb/tb_wb_master_protocol_checker.sv
// Bench for wb_master_protocol_checker: a strict instance (A) and a permissive instance (B)
// watch the same bus; a rule-level model predicts both every clock.
module tb_wb_master_protocol_checker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc = 0, stb = 0, we = 0, ack = 0, stall = 0, err = 0;
    logic [31:0] addr = '0, data = '0, idata = '0;
    logic [3:0]  sel = 4'hf;

    logic [3:0] a_nreqs, a_nacks, a_out, b_nreqs, b_nacks, b_out;
    logic [9:0] a_viol, b_viol;
    logic       a_any, b_any;

    int ncmp = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    wb_master_protocol_checker #(.AW(32), .DW(32), .F_LGDEPTH(4), .F_MAX_STALL(3),
        .F_MAX_ACK_DELAY(4), .F_OPT_RMW_BUS_OPTION(0), .F_OPT_DISCONTINUOUS(0)) dut_a (
        .i_clk(clk), .i_reset_n(rst_n), .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
        .i_wb_addr(addr), .i_wb_data(data), .i_wb_sel(sel), .i_wb_ack(ack),
        .i_wb_stall(stall), .i_wb_idata(idata), .i_wb_err(err),
        .o_f_nreqs(a_nreqs), .o_f_nacks(a_nacks), .o_f_outstanding(a_out),
        .o_viol(a_viol), .o_viol_any(a_any));

    wb_master_protocol_checker #(.AW(32), .DW(32), .F_LGDEPTH(4), .F_MAX_STALL(0),
        .F_MAX_ACK_DELAY(0), .F_OPT_RMW_BUS_OPTION(1), .F_OPT_DISCONTINUOUS(1)) dut_b (
        .i_clk(clk), .i_reset_n(rst_n), .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
        .i_wb_addr(addr), .i_wb_data(data), .i_wb_sel(sel), .i_wb_ack(ack),
        .i_wb_stall(stall), .i_wb_idata(idata), .i_wb_err(err),
        .o_f_nreqs(b_nreqs), .o_f_nacks(b_nacks), .o_f_outstanding(b_out),
        .o_viol(b_viol), .o_viol_any(b_any));

    // Reference model: configuration 0 mirrors dut_a, 1 mirrors dut_b.
    int        P_DISC[2] = '{0, 1};
    int        P_RMW[2]  = '{0, 1};
    int        P_MS[2]   = '{3, 0};
    int        P_MA[2]   = '{4, 0};
    int        m_nreq, m_nack;
    int        m_srun[2], m_arun[2];
    bit        m_seen;
    bit [9:0]  m_viol[2];
    bit        h_cyc, h_stb, h_stall, h_we;
    bit [31:0] h_addr, h_data;
    bit [3:0]  h_sel;

    task automatic model_reset();
        m_nreq = 0; m_nack = 0; m_seen = 0;
        for (int k = 0; k < 2; k++) begin
            m_srun[k] = 0; m_arun[k] = 0; m_viol[k] = '0;
        end
        h_cyc = 0; h_stb = 0; h_stall = 0; h_we = 0; h_addr = '0; h_data = '0; h_sel = '0;
    endtask

    function automatic int m_outs();
        return ((m_nreq - m_nack) % 16 + 16) % 16;
    endfunction

    task automatic model_update();
        bit acc, resp;
        int outs, sr, ar;
        bit [9:0] s;
        acc  = cyc && stb && !stall;
        resp = ack || err;
        outs = m_outs();
        for (int k = 0; k < 2; k++) begin
            s = '0;
            s[0] = stb && !cyc;
            s[1] = h_cyc && h_stb && h_stall && cyc && stb &&
                   (addr != h_addr || we != h_we || sel != h_sel || (we && data != h_data));
            s[2] = cyc && stb && outs != 0 && we != h_we;
            s[3] = P_DISC[k] == 0 && cyc && stb && !h_stb && m_seen;
            s[4] = P_RMW[k] == 0 && cyc && !stb && outs == 0 && h_cyc;
            s[5] = resp && outs == 0;
            s[6] = resp && !cyc;
            sr = (cyc && stb && stall) ? m_srun[k] + 1 : 0;
            ar = (cyc && outs != 0 && !resp) ? m_arun[k] + 1 : 0;
            s[7] = P_MS[k] > 0 && sr >= P_MS[k];
            s[8] = P_MA[k] > 0 && ar >= P_MA[k];
            s[9] = acc && !err && m_nreq == 15;
            m_viol[k] |= s;
            m_srun[k] = (!cyc || err) ? 0 : sr;
            m_arun[k] = (!cyc || err) ? 0 : ar;
        end
        if (!cyc || err) begin
            m_nreq = 0; m_nack = 0;
        end else begin
            if (acc && m_nreq < 15) m_nreq++;
            if (ack && m_nack < 15) m_nack++;
        end
        m_seen = cyc && (m_seen || stb);
        h_cyc = cyc; h_stb = stb; h_stall = stall; h_we = we;
        h_addr = addr; h_data = data; h_sel = sel;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, " A.nreqs"}, 32'(a_nreqs), 32'(m_nreq));
        chk({tag, " A.nacks"}, 32'(a_nacks), 32'(m_nack));
        chk({tag, " A.outst"}, 32'(a_out), 32'(m_outs()));
        chk({tag, " A.viol"}, 32'(a_viol), 32'(m_viol[0]));
        chk({tag, " A.any"}, 32'(a_any), 32'(|m_viol[0]));
        chk({tag, " B.nreqs"}, 32'(b_nreqs), 32'(m_nreq));
        chk({tag, " B.viol"}, 32'(b_viol), 32'(m_viol[1]));
        chk({tag, " B.any"}, 32'(b_any), 32'(|m_viol[1]));
    endtask

    task automatic drive(input logic c, input logic s, input logic w, input logic [31:0] a,
                         input logic st, input logic ak, input logic e);
        cyc = c; stb = s; we = w; addr = a; stall = st; ack = ak; err = e;
    endtask

    // One clock: model advances on the same inputs, outputs sampled 1 time unit after the edge.
    task automatic step(input string tag);
        model_update();
        @(posedge clk); #1;
        chk_model(tag);
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 32'h0, 0, 0, 0);
        data = '0; sel = 4'hf;
        rst_n = 1'b0;
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic       cyc, stb, we, stall, ack, err;
        logic [31:0] addr;
        logic [3:0] e_nreqs, e_nacks, e_out;
        logic [9:0] e_viol;
    } vec_t;

    vec_t vt[8];

    initial begin
        vt[0] = '{1, 1, 0, 0, 0, 0, 32'h10, 4'd1, 4'd0, 4'd1, 10'h0};
        vt[1] = '{1, 0, 0, 0, 1, 0, 32'h10, 4'd1, 4'd1, 4'd0, 10'h0};
        vt[2] = '{0, 0, 0, 0, 0, 0, 32'h00, 4'd0, 4'd0, 4'd0, 10'h0};
        vt[3] = '{1, 1, 1, 0, 0, 0, 32'h20, 4'd1, 4'd0, 4'd1, 10'h0};
        vt[4] = '{1, 1, 1, 0, 1, 0, 32'h24, 4'd2, 4'd1, 4'd1, 10'h0};
        vt[5] = '{1, 1, 1, 0, 1, 0, 32'h28, 4'd3, 4'd2, 4'd1, 10'h0};
        vt[6] = '{1, 1, 1, 0, 0, 1, 32'h2C, 4'd0, 4'd0, 4'd0, 10'h0};
        vt[7] = '{0, 0, 0, 0, 0, 0, 32'h00, 4'd0, 4'd0, 4'd0, 10'h0};

        model_reset();
        #12;
        chk("reset A.nreqs", 32'(a_nreqs), 32'd0);
        chk("reset A.viol", 32'(a_viol), 32'd0);
        chk("reset B.any", 32'(b_any), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Table: single read, pipelined writes with accept+ack, err terminating a cycle.
        for (int i = 0; i < 8; i++) begin
            drive(vt[i].cyc, vt[i].stb, vt[i].we, vt[i].addr, vt[i].stall, vt[i].ack, vt[i].err);
            step("table");
            chk($sformatf("vec%0d A.nreqs", i), 32'(a_nreqs), 32'(vt[i].e_nreqs));
            chk($sformatf("vec%0d A.nacks", i), 32'(a_nacks), 32'(vt[i].e_nacks));
            chk($sformatf("vec%0d A.outst", i), 32'(a_out), 32'(vt[i].e_out));
            chk($sformatf("vec%0d A.viol", i), 32'(a_viol), 32'(vt[i].e_viol));
            chk($sformatf("vec%0d B.viol", i), 32'(b_viol), 32'(vt[i].e_viol));
        end

        // Asynchronous reset mid-cycle after two accepted reads.
        do_reset();
        drive(1, 1, 0, 32'h10, 0, 0, 0); step("rst_mid");
        drive(1, 1, 0, 32'h14, 0, 0, 0); step("rst_mid");
        chk("pre-reset nreqs", 32'(a_nreqs), 32'd2);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("async reset nreqs", 32'(a_nreqs), 32'd0);
        chk("async reset outst", 32'(a_out), 32'd0);
        chk("async reset viol", 32'(a_viol), 32'd0);
        drive(0, 0, 0, 32'h0, 0, 0, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Request address changed while stalled.
        do_reset();
        drive(1, 1, 0, 32'h10, 1, 0, 0); step("stall_chg");
        drive(1, 1, 0, 32'h14, 1, 0, 0); step("stall_chg");
        chk("stall change bit1", 32'(a_viol[1]), 32'd1);
        chk("stall change any", 32'(a_any), 32'd1);
        drive(0, 0, 0, 32'h0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step("stall_chg");
        chk("stall change sticky", 32'(b_viol[1]), 32'd1);

        // Ack with nothing outstanding, then ack outside a cycle.
        do_reset();
        drive(1, 0, 0, 32'h0, 0, 1, 0); step("ack_none");
        chk("ack no req bit5", 32'(a_viol[5]), 32'd1);
        do_reset();
        drive(0, 0, 0, 32'h0, 0, 1, 0); step("ack_nocyc");
        chk("ack no cyc bit6", 32'(a_viol[6]), 32'd1);

        // STB 1,0,1 inside one CYC: strict flags it, permissive does not.
        do_reset();
        drive(1, 1, 0, 32'h10, 0, 0, 0); step("disc");
        drive(1, 0, 0, 32'h10, 0, 0, 0); step("disc");
        drive(1, 1, 0, 32'h14, 0, 0, 0); step("disc");
        chk("discontinuous A bit3", 32'(a_viol[3]), 32'd1);
        chk("discontinuous B viol", 32'(b_viol), 32'd0);

        // CYC held idle for two clocks.
        do_reset();
        drive(1, 0, 0, 32'h0, 0, 0, 0); step("idle");
        chk("idle first clk bit4", 32'(a_viol[4]), 32'd0);
        step("idle");
        chk("idle A bit4", 32'(a_viol[4]), 32'd1);
        chk("idle B viol", 32'(b_viol), 32'd0);

        // Stall timeout at 3 clocks.
        do_reset();
        drive(1, 1, 0, 32'h10, 1, 0, 0);
        step("stall_to"); step("stall_to");
        chk("stall 2 clk bit7", 32'(a_viol[7]), 32'd0);
        step("stall_to");
        chk("stall 3 clk bit7", 32'(a_viol[7]), 32'd1);

        // Ack timeout at 4 clocks.
        do_reset();
        drive(1, 1, 0, 32'h10, 0, 0, 0); step("ack_to");
        drive(1, 0, 0, 32'h10, 0, 0, 0);
        for (int i = 0; i < 3; i++) step("ack_to");
        chk("ack wait 3 bit8", 32'(a_viol[8]), 32'd0);
        step("ack_to");
        chk("ack wait 4 bit8", 32'(a_viol[8]), 32'd1);
        chk("ack wait B bit8", 32'(b_viol[8]), 32'd0);

        // 16 accepts into a 4-bit counter.
        do_reset();
        for (int i = 0; i < 15; i++) begin
            drive(1, 1, 0, 32'(i * 4), 0, 0, 0); step("ovf");
        end
        chk("15 accepts nreqs", 32'(a_nreqs), 32'd15);
        chk("15 accepts bit9", 32'(a_viol[9]), 32'd0);
        drive(1, 1, 0, 32'h100, 0, 0, 0); step("ovf");
        chk("16 accepts bit9", 32'(a_viol[9]), 32'd1);
        chk("16 accepts nreqs", 32'(a_nreqs), 32'd15);
        chk("16 accepts B nreqs", 32'(b_nreqs), 32'd15);

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 800; n++) begin
            if (n % 40 == 39) do_reset();
            cyc   = ($urandom_range(0, 9) != 0);
            stb   = ($urandom_range(0, 2) != 0);
            stall = ($urandom_range(0, 3) == 0);
            ack   = ($urandom_range(0, 2) == 0);
            err   = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 7) == 0) we = ~we;
            if ($urandom_range(0, 3) == 0) addr = 32'($urandom_range(0, 3) * 4);
            if ($urandom_range(0, 3) == 0) data = $urandom;
            if ($urandom_range(0, 7) == 0) sel = 4'($urandom_range(0, 15));
            step("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/wb_master_protocol_checker.md
Name: wb_master_protocol_checker

Overview:
Synthesizable, non-intrusive Wishbone B4 pipelined-mode protocol monitor for a bus master port. It observes a master/slave channel, counts accepted requests and acknowledgements within each bus cycle, and raises sticky violation flags when either side breaks the protocol. It sits beside any Wishbone master, such as the instruction prefetch unit, and drives nothing on the bus.

Parameters:
AW, 32, address width (word address).
DW, 32, data width; select width is DW/8.
F_LGDEPTH, 4, width of the request/ack/outstanding counters.
F_MAX_STALL, 0, maximum consecutive stalled request clocks; 0 disables the check.
F_MAX_ACK_DELAY, 0, maximum clocks with requests outstanding and no ack/err; 0 disables the check.
F_OPT_RMW_BUS_OPTION, 1, 1 allows CYC held idle (no STB, nothing outstanding) for read-modify-write.
F_OPT_DISCONTINUOUS, 0, 1 allows STB to drop and re-assert inside one CYC.

Ports:
i_clk  in  1  clock; all logic on rising edge
i_reset_n  in  1  asynchronous, active-low reset
i_wb_cyc  in  1  master CYC
i_wb_stb  in  1  master STB
i_wb_we  in  1  master WE
i_wb_addr  in  AW  master address
i_wb_data  in  DW  master write data
i_wb_sel  in  DW/8  master byte select
i_wb_ack  in  1  slave ACK
i_wb_stall  in  1  slave STALL
i_wb_idata  in  DW  slave read data (observed only, not checked)
i_wb_err  in  1  slave ERR
o_f_nreqs  out  F_LGDEPTH  requests accepted this cycle
o_f_nacks  out  F_LGDEPTH  ack/err responses this cycle
o_f_outstanding  out  F_LGDEPTH  nreqs minus nacks, combinational
o_viol  out  10  sticky violation flags, bit list below
o_viol_any  out  1  OR of o_viol

Behaviour:
- Reset: async, active-low. Clears nreqs, nacks, all timers, o_viol and pipeline-history registers to 0. Counters and flags read 0 while reset is low.
- Request accepted: cyc & stb & !stall. nreqs increments by 1.
- Response: cyc & (ack | err). nacks increments by 1.
- Counters and timers clear on the next edge when cyc=0 or err=1, because ERR terminates the cycle. In that case the increment rule is overridden.
- History registers hold the previous clock's cyc, stb, stall, we, addr, data and sel.
- Flag bits. Each is set on the edge after the condition is seen, and stays set until reset:
  - [0] STB without CYC.
  - [1] Request changed while stalled. Previous clock had cyc & stb & stall, current clock has cyc & stb, and any of addr, we, sel differs, or data differs while we=1.
  - [2] WE changed while cyc=1 and outstanding > 0 and stb=1.
  - [3] Discontinuous STB. Only when F_OPT_DISCONTINUOUS=0: stb rises while cyc has been continuously high and stb was already high earlier in the same cycle.
  - [4] Idle CYC. Only when F_OPT_RMW_BUS_OPTION=0: cyc=1, stb=0, outstanding=0, and this is not the first clock of the cycle.
  - [5] ACK or ERR with outstanding=0. A request accepted in the same clock does not count as outstanding; an ack needs at least 1 clock of latency.
  - [6] ACK or ERR while cyc=0.
  - [7] Stall timeout. Stall counter counts clocks of cyc & stb & stall and resets otherwise. Flag sets when count ≥ F_MAX_STALL (F_MAX_STALL > 0).
  - [8] Ack timeout. Counter counts clocks with outstanding > 0 and no ack/err, and resets on ack/err or when cyc drops. Flag sets when count ≥ F_MAX_ACK_DELAY (F_MAX_ACK_DELAY > 0).
  - [9] Counter overflow. Increment attempted with nreqs = 2^F_LGDEPTH−1. On overflow, counters saturate rather than wrap.
- Simultaneous events:
  - Request accept and ack in the same clock: both counters increment.
  - Err plus accept: counters clear.
  - Several flags may set on one edge.
- No outputs affect bus signals.

Test Plan:
- Reset mid-cycle: after 2 accepted reads, drive i_reset_n=0 asynchronously → all counters and o_viol read 0 before the next clock edge.
- Single read: stb=1, stall=0 for 1 clk at addr 0x10, ack 1 clk later, cyc drops → nreqs=1, nacks=0, outstanding=1 after accept; 1/1/0 after ack; 0/0/0 after cyc drops; o_viol=0.
- Stalled request with address changed from 0x10 to 0x14 while stall=1 → o_viol[1]=1, o_viol_any=1, still set 5 clocks later.
- Ack with no request, and ack with cyc=0 → o_viol[5]=1 and o_viol[6]=1 respectively.
- Discontinuous and idle-CYC violations with F_OPT_DISCONTINUOUS=0, F_OPT_RMW_BUS_OPTION=0:
  - stb 1,0,1 inside one cyc → o_viol[3]=1.
  - cyc held 2 clocks with no stb or outstanding → o_viol[4]=1.
  - With both options =1, the same traffic gives o_viol=0.
- Timeouts and overflow with F_MAX_STALL=3, F_MAX_ACK_DELAY=4:
  - stall held 3 clocks → bit7 set.
  - Request unacked 4 clocks → bit8 set.
  - 16 accepts with F_LGDEPTH=4 → bit9 set, nreqs stays 15.
